// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - round-robin arbiter from many consumers onto a few memory channels
//
// Each memory channel runs its own claim/wait/relay FSM. An idle channel claims
// the first requesting consumer at or above rr_ptr that no other channel owns;
// channels search in ascending index within one cycle, so a consumer claimed by
// a lower channel is skipped by higher ones.
//
// Ports:
//   clock, reset_n                  single clock, asynchronous active-low reset
//   consumer_read_valid/addr        per-consumer read request (packed, consumer i at slice i)
//   consumer_read_ready/data        read complete strobe and per-consumer held read data
//   consumer_write_valid/addr/data  per-consumer write request
//   consumer_write_ready            write complete strobe
//   mem_read_valid/addr, mem_read_ready/data         per-channel memory read port
//   mem_write_valid/addr/data, mem_write_ready       per-channel memory write port
module memory_controller #(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 512
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0]  consumer_read_addr,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_WIDTH-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0]  consumer_write_addr,
    input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]              mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   mem_read_addr,
    input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]              mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   mem_write_addr,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY
    } ch_state_t;

    ch_state_t             state_q [NUM_CHANNELS];
    ch_state_t             state_d [NUM_CHANNELS];
    logic [CW-1:0]         owner_q [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0] addr_q  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] wdata_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] rdata_q [NUM_CONSUMERS];
    logic [CW-1:0]         rr_ptr;
    logic [CW-1:0]         rr_next;

    logic [NUM_CONSUMERS-1:0] owned;
    logic [NUM_CONSUMERS-1:0] claimed;
    logic [NUM_CHANNELS-1:0]  grant;
    logic [NUM_CHANNELS-1:0]  grant_read;
    logic [CW-1:0]            grant_idx [NUM_CHANNELS];

    // A consumer stays owned from claim until its channel returns to IDLE.
    always_comb begin
        owned = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (state_q[ch] != IDLE) owned[owner_q[ch]] = 1'b1;
        end
    end

    // Cascaded search: claimed accumulates across channels so a consumer taken
    // by a lower channel this cycle is invisible to the higher ones. last_off
    // is the furthest search offset that produced a grant; rr_ptr moves past it.
    always_comb begin
        logic [CW-1:0] idx;
        logic          found;
        int            last_off;
        claimed    = '0;
        grant      = '0;
        grant_read = '0;
        idx        = '0;
        found      = 1'b0;
        last_off   = 0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_idx[ch] = '0;
            found         = 1'b0;
            if (state_q[ch] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = CW'((int'(rr_ptr) + k) % NUM_CONSUMERS);
                    if (!found && (consumer_read_valid[idx] || consumer_write_valid[idx])
                        && !owned[idx] && !claimed[idx]) begin
                        found          = 1'b1;
                        claimed[idx]   = 1'b1;
                        grant[ch]      = 1'b1;
                        grant_idx[ch]  = idx;
                        grant_read[ch] = consumer_read_valid[idx];
                        if (k > last_off) last_off = k;
                    end
                end
            end
        end
        rr_next = (|grant) ? CW'((int'(rr_ptr) + last_off + 1) % NUM_CONSUMERS) : rr_ptr;
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            case (state_q[ch])
                IDLE:        if (grant[ch]) state_d[ch] = grant_read[ch] ? READ_WAIT : WRITE_WAIT;
                READ_WAIT:   if (mem_read_ready[ch]) state_d[ch] = READ_RELAY;
                WRITE_WAIT:  if (mem_write_ready[ch]) state_d[ch] = WRITE_RELAY;
                READ_RELAY:  if (!consumer_read_valid[owner_q[ch]]) state_d[ch] = IDLE;
                WRITE_RELAY: if (!consumer_write_valid[owner_q[ch]]) state_d[ch] = IDLE;
                default:     state_d[ch] = IDLE;
            endcase
        end
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        consumer_read_data   = '0;
        mem_read_valid       = '0;
        mem_write_valid      = '0;
        mem_read_addr        = '0;
        mem_write_addr       = '0;
        mem_write_data       = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            mem_read_valid[ch]  = (state_q[ch] == READ_WAIT);
            mem_write_valid[ch] = (state_q[ch] == WRITE_WAIT);
            mem_read_addr[ch*ADDR_WIDTH +: ADDR_WIDTH]  = addr_q[ch];
            mem_write_addr[ch*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[ch];
            mem_write_data[ch*DATA_WIDTH +: DATA_WIDTH] = wdata_q[ch];
            if (state_q[ch] == READ_RELAY)  consumer_read_ready[owner_q[ch]]  = 1'b1;
            if (state_q[ch] == WRITE_RELAY) consumer_write_ready[owner_q[ch]] = 1'b1;
        end
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
            consumer_read_data[c*DATA_WIDTH +: DATA_WIDTH] = rdata_q[c];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                owner_q[ch] <= '0;
                addr_q[ch]  <= '0;
                wdata_q[ch] <= '0;
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                rdata_q[c] <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                if (grant[ch]) begin
                    owner_q[ch] <= grant_idx[ch];
                    addr_q[ch]  <= grant_read[ch]
                        ? consumer_read_addr[int'(grant_idx[ch])*ADDR_WIDTH +: ADDR_WIDTH]
                        : consumer_write_addr[int'(grant_idx[ch])*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_q[ch] <= consumer_write_data[int'(grant_idx[ch])*DATA_WIDTH +: DATA_WIDTH];
                end
                // Read data lands in the owner's slot and is held there until
                // that consumer's next read completes.
                if (state_q[ch] == READ_WAIT && mem_read_ready[ch]) begin
                    rdata_q[owner_q[ch]] <= mem_read_data[ch*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - scoreboard bench for memory_controller
module tb_memory_controller;
    localparam int NC  = 4;
    localparam int NCH = 2;
    localparam int AW  = 8;
    localparam int DW  = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [NC-1:0]     consumer_read_valid  = '0;
    logic [NC*AW-1:0]  consumer_read_addr   = '0;
    logic [NC-1:0]     consumer_read_ready;
    logic [NC*DW-1:0]  consumer_read_data;
    logic [NC-1:0]     consumer_write_valid = '0;
    logic [NC*AW-1:0]  consumer_write_addr  = '0;
    logic [NC*DW-1:0]  consumer_write_data  = '0;
    logic [NC-1:0]     consumer_write_ready;
    logic [NCH-1:0]    mem_read_valid;
    logic [NCH*AW-1:0] mem_read_addr;
    logic [NCH-1:0]    mem_read_ready;
    logic [NCH*DW-1:0] mem_read_data;
    logic [NCH-1:0]    mem_write_valid;
    logic [NCH*AW-1:0] mem_write_addr;
    logic [NCH*DW-1:0] mem_write_data;
    logic [NCH-1:0]    mem_write_ready;

    memory_controller #(
        .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .consumer_read_valid(consumer_read_valid), .consumer_read_addr(consumer_read_addr),
        .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid), .consumer_write_addr(consumer_write_addr),
        .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: ready after a programmable number of valid cycles.
    logic [DW-1:0] mem_model [256];
    int rd_delay = 0;
    int wr_delay = 0;
    int rcnt [NCH] = '{default: 0};
    int wcnt [NCH] = '{default: 0};

    always @(posedge clock) begin
        for (int ch = 0; ch < NCH; ch++) begin
            rcnt[ch] <= (mem_read_valid[ch] && !mem_read_ready[ch]) ? rcnt[ch] + 1 : 0;
            wcnt[ch] <= (mem_write_valid[ch] && !mem_write_ready[ch]) ? wcnt[ch] + 1 : 0;
        end
    end

    always_comb begin
        mem_read_ready  = '0;
        mem_write_ready = '0;
        mem_read_data   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            mem_read_ready[ch]  = mem_read_valid[ch] && (rcnt[ch] >= rd_delay);
            mem_write_ready[ch] = mem_write_valid[ch] && (wcnt[ch] >= wr_delay);
            if (mem_read_ready[ch]) mem_read_data[ch*DW +: DW] = mem_model[mem_read_addr[ch*AW +: AW]];
        end
    end

    // Log of memory reads as they start: ch*256 + addr.
    int rlog [$];
    logic [NCH-1:0] prev_rv = '0;
    always @(negedge clock) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (mem_read_valid[ch] && !prev_rv[ch]) rlog.push_back(ch * 256 + int'(mem_read_addr[ch*AW +: AW]));
        end
        prev_rv = mem_read_valid;
    end

    // Requests from the main sequence (written only there).
    int            rd_issue    [NC] = '{default: 0};
    int            wr_issue    [NC] = '{default: 0};
    logic [AW-1:0] rd_addr_cfg [NC];
    logic [AW-1:0] wr_addr_cfg [NC];
    logic [DW-1:0] wr_data_cfg [NC];
    int            rd_hold_cfg [NC] = '{default: 0};

    // Agent state (written only by the agent).
    typedef struct {
        int            cons;
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb [$];

    int            rd_taken    [NC] = '{default: 0};
    int            wr_taken    [NC] = '{default: 0};
    bit            rd_busy     [NC] = '{default: 0};
    bit            wr_busy     [NC] = '{default: 0};
    bit            rd_seen     [NC] = '{default: 0};
    int            rd_hold     [NC] = '{default: 0};
    int            rd_start    [NC] = '{default: 0};
    int            rd_lat      [NC] = '{default: 0};
    int            rd_done_cyc [NC] = '{default: 0};
    int            rd_done_cnt [NC] = '{default: 0};
    int            rd_done_rnd [NC] = '{default: 0};
    int            wr_done_cyc [NC] = '{default: 0};
    logic [DW-1:0] rd_last     [NC];
    int            rounds = 0;
    int            last_done_cyc = -1;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    task automatic sb_match(input int c, input bit is_wr, input logic [AW-1:0] addr,
                            input bit use_addr, input logic [DW-1:0] got);
        int hit;
        hit = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (hit < 0 && (c < 0 || sb[i].cons == c) && sb[i].is_wr == is_wr
                && (!use_addr || sb[i].addr == addr)) hit = i;
        end
        if (hit < 0) begin
            check(is_wr ? "wr_unexpected" : "rd_unexpected", 1, 0);
        end else begin
            check(is_wr ? "wr_data" : "rd_data", 32'(got), 32'(sb[hit].data));
            sb.delete(hit);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            for (int c = 0; c < NC; c++) begin
                consumer_read_valid[c]  = 1'b0;
                consumer_write_valid[c] = 1'b0;
                rd_busy[c]  = 1'b0;
                wr_busy[c]  = 1'b0;
                rd_seen[c]  = 1'b0;
                rd_taken[c] = rd_issue[c];
                wr_taken[c] = wr_issue[c];
            end
            sb.delete();
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (mem_write_valid[ch] && mem_write_ready[ch]) begin
                    last_wr_addr = mem_write_addr[ch*AW +: AW];
                    last_wr_data = mem_write_data[ch*DW +: DW];
                    sb_match(-1, 1'b1, last_wr_addr, 1'b1, last_wr_data);
                end
            end
            for (int c = 0; c < NC; c++) begin
                bit rd_launch;
                bit wr_launch;
                rd_launch = !rd_busy[c] && (rd_issue[c] != rd_taken[c]);
                wr_launch = !wr_busy[c] && (wr_issue[c] != wr_taken[c]);
                if (consumer_read_ready[c]) begin
                    if (!rd_busy[c]) begin
                        check($sformatf("rd_spurious_c%0d", c), 1, 0);
                    end else begin
                        if (!rd_seen[c]) begin
                            rd_seen[c]     = 1'b1;
                            rd_lat[c]      = cyc - rd_start[c] + 1;
                            rd_done_cyc[c] = cyc;
                            rd_done_cnt[c]++;
                            if (cyc != last_done_cyc) begin
                                rounds++;
                                last_done_cyc = cyc;
                            end
                            rd_done_rnd[c] = rounds;
                            rd_last[c]     = consumer_read_data[c*DW +: DW];
                            sb_match(c, 1'b0, '0, 1'b0, rd_last[c]);
                        end else begin
                            check("rd_hold_data", 32'(consumer_read_data[c*DW +: DW]), 32'(rd_last[c]));
                        end
                        if (rd_hold[c] == 0) begin
                            consumer_read_valid[c] = 1'b0;
                            rd_busy[c] = 1'b0;
                            rd_seen[c] = 1'b0;
                        end else begin
                            rd_hold[c]--;
                        end
                    end
                end
                if (consumer_write_ready[c]) begin
                    if (!wr_busy[c]) begin
                        check($sformatf("wr_spurious_c%0d", c), 1, 0);
                    end else begin
                        wr_done_cyc[c] = cyc;
                        consumer_write_valid[c] = 1'b0;
                        wr_busy[c] = 1'b0;
                    end
                end
                if (rd_launch) begin
                    rd_taken[c]++;
                    rd_busy[c]  = 1'b1;
                    rd_start[c] = cyc;
                    rd_hold[c]  = rd_hold_cfg[c];
                    consumer_read_addr[c*AW +: AW] = rd_addr_cfg[c];
                    consumer_read_valid[c] = 1'b1;
                    sb.push_back('{cons: c, is_wr: 1'b0, addr: rd_addr_cfg[c], data: mem_model[rd_addr_cfg[c]]});
                end
                if (wr_launch) begin
                    wr_taken[c]++;
                    wr_busy[c] = 1'b1;
                    consumer_write_addr[c*AW +: AW] = wr_addr_cfg[c];
                    consumer_write_data[c*DW +: DW] = wr_data_cfg[c];
                    consumer_write_valid[c] = 1'b1;
                    sb.push_back('{cons: c, is_wr: 1'b1, addr: wr_addr_cfg[c], data: wr_data_cfg[c]});
                end
            end
        end
    end

    function automatic bit all_idle();
        bit idle;
        idle = 1'b1;
        for (int c = 0; c < NC; c++) begin
            if (rd_busy[c] || wr_busy[c] || rd_issue[c] != rd_taken[c] || wr_issue[c] != wr_taken[c]) idle = 1'b0;
        end
        return idle;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        while (n < budget && !all_idle()) begin
            tick();
            n++;
        end
        if (!all_idle()) check("idle_timeout", 0, 1);
        tick();
    endtask

    task automatic issue_read(input int c, input logic [AW-1:0] a, input int hold);
        rd_addr_cfg[c] = a;
        rd_hold_cfg[c] = hold;
        rd_issue[c]++;
    endtask

    initial begin
        int base_log;
        int base_cnt [NC];
        int base_rnd;
        for (int a = 0; a < 256; a++) mem_model[a] = 16'(a * 16'h0101) ^ 16'h5A00;
        mem_model[8'h12] = 16'hBEEF;

        // Reset state.
        repeat (3) tick();
        check("rst_rd_ready", 32'(consumer_read_ready), 0);
        check("rst_wr_ready", 32'(consumer_write_ready), 0);
        check("rst_mem_rv", 32'(mem_read_valid), 0);
        check("rst_mem_wv", 32'(mem_write_valid), 0);
        check("rst_mem_raddr", 32'(mem_read_addr), 0);
        check("rst_rd_data", 32'(consumer_read_data[31:0]), 0);
        reset_n = 1'b1;
        tick();

        // All four read at once: 0/1 first, then 2/3.
        base_log = rlog.size();
        for (int c = 0; c < NC; c++) begin
            base_cnt[c] = rd_done_cnt[c];
            issue_read(c, 8'(8'h20 + c), 0);
        end
        wait_idle(60);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("all4_served_once_c%0d", c), 32'(rd_done_cnt[c] - base_cnt[c]), 1);
            check($sformatf("all4_lat_c%0d", c), 32'(rd_lat[c]), (c < 2) ? 3 : 6);
        end
        check("all4_log_len", 32'(rlog.size() - base_log), 4);
        if (rlog.size() - base_log >= 4) begin
            check("all4_log0", 32'(rlog[base_log]),     32'h020);
            check("all4_log1", 32'(rlog[base_log + 1]), 32'h121);
            check("all4_log2", 32'(rlog[base_log + 2]), 32'h022);
            check("all4_log3", 32'(rlog[base_log + 3]), 32'h123);
        end
        check("all4_rr_ptr", 32'(dut.rr_ptr), 0);

        // Consumer 1 reads 0x12, immediate memory, held two extra cycles.
        issue_read(1, 8'h12, 2);
        wait_idle(40);
        check("c1_lat", 32'(rd_lat[1]), 3);
        check("c1_data", 32'(rd_last[1]), 32'hBEEF);
        check("c1_ready_low", 32'(consumer_read_ready[1]), 0);
        check("c1_data_held", 32'(consumer_read_data[1*DW +: DW]), 32'hBEEF);

        // Consumer 2 read and write together: read first.
        wr_addr_cfg[2] = 8'h06;
        wr_data_cfg[2] = 16'h1234;
        issue_read(2, 8'h05, 0);
        wr_issue[2]++;
        wait_idle(60);
        check("c2_rd_data", 32'(rd_last[2]), 32'(mem_model[8'h05]));
        check("c2_rd_before_wr", 32'(rd_done_cyc[2] < wr_done_cyc[2]), 1);
        check("c2_wr_addr", 32'(last_wr_addr), 32'h06);
        check("c2_wr_data", 32'(last_wr_data), 32'h1234);

        // Slow memory: five extra cycles.
        rd_delay = 5;
        issue_read(0, 8'h40, 0);
        for (int n = 0; n < 30 && (rd_busy[0] || rd_issue[0] != rd_taken[0]); n++) begin
            tick();
            if (mem_read_valid[0]) check("slow_addr_stable", 32'(mem_read_addr[AW-1:0]), 32'h40);
        end
        wait_idle(40);
        check("slow_lat", 32'(rd_lat[0]), 8);
        check("slow_data", 32'(rd_last[0]), 32'(mem_model[8'h40]));

        // Reset during READ_WAIT.
        base_cnt[1] = rd_done_cnt[1];
        issue_read(1, 8'h33, 0);
        repeat (3) tick();
        check("rstmid_pending", 32'(mem_read_valid), 32'b01);
        reset_n = 1'b0;
        #1;
        check("rstmid_mem_rv", 32'(mem_read_valid), 0);
        check("rstmid_mem_raddr", 32'(mem_read_addr), 0);
        check("rstmid_rd_data", 32'(consumer_read_data), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("rstmid_no_completion", 32'(rd_done_cnt[1] - base_cnt[1]), 0);
        rd_delay = 0;
        issue_read(3, 8'h44, 0);
        wait_idle(40);
        check("post_rst_lat", 32'(rd_lat[3]), 3);
        check("post_rst_data", 32'(rd_last[3]), 32'(mem_model[8'h44]));

        // Consumer 3 pending while 0..2 keep re-requesting.
        base_cnt[3] = rd_done_cnt[3];
        base_rnd = rounds;
        for (int c = 0; c < NC; c++) issue_read(c, 8'(8'h60 + c), 0);
        for (int n = 0; n < 100 && rd_done_cnt[3] == base_cnt[3]; n++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                if (!rd_busy[c] && rd_issue[c] == rd_taken[c]) issue_read(c, 8'(8'h60 + c), 0);
            end
        end
        check("fair_c3_served", 32'(rd_done_cnt[3] - base_cnt[3]), 1);
        check("fair_c3_rounds", 32'((rd_done_rnd[3] - base_rnd) <= 2), 1);
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter NUM_CONSUMERS, default 8: number of processing-block requesters.
REQ-002 Parameter NUM_CHANNELS, default 2: number of concurrent memory-side channels, 1..NUM_CONSUMERS.
REQ-003 Parameter ADDR_WIDTH, default 16: address width in bits.
REQ-004 Parameter DATA_WIDTH, default 512: data word width in bits.
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request.
REQ-008 consumer_read_addr  input  NUM_CONSUMERS*ADDR_WIDTH  packed read addresses, consumer i at slice i.
REQ-009 consumer_read_ready  output  NUM_CONSUMERS  read complete, data valid.
REQ-010 consumer_read_data  output  NUM_CONSUMERS*DATA_WIDTH  packed read data.
REQ-011 consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request.
REQ-012 consumer_write_addr  input  NUM_CONSUMERS*ADDR_WIDTH  packed write addresses.
REQ-013 consumer_write_data  input  NUM_CONSUMERS*DATA_WIDTH  packed write data.
REQ-014 consumer_write_ready  output  NUM_CONSUMERS  write complete.
REQ-015 mem_read_valid  output  NUM_CHANNELS  per-channel memory read request.
REQ-016 mem_read_addr  output  NUM_CHANNELS*ADDR_WIDTH  packed memory read addresses.
REQ-017 mem_read_ready  input  NUM_CHANNELS  memory read data valid.
REQ-018 mem_read_data  input  NUM_CHANNELS*DATA_WIDTH  packed memory read data.
REQ-019 mem_write_valid  output  NUM_CHANNELS  per-channel memory write request.
REQ-020 mem_write_addr  output  NUM_CHANNELS*ADDR_WIDTH  packed memory write addresses.
REQ-021 mem_write_data  output  NUM_CHANNELS*DATA_WIDTH  packed memory write data.
REQ-022 mem_write_ready  input  NUM_CHANNELS  memory write accepted.

Function
REQ-023 Each channel SHALL run an FSM: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
REQ-024 IDLE: channel SHALL search consumers from rr_ptr upward mod NUM_CONSUMERS; first consumer with read or write valid, not owned by another channel, is claimed.
REQ-025 Channels SHALL search in ascending channel index within one cycle; a consumer claimed by a lower channel that cycle is skipped by higher channels.
REQ-026 Read SHALL take priority over write when one consumer asserts both.
REQ-027 On claim: registered address (and write data) SHALL drive the channel's mem_*_addr/data, mem_*_valid=1 from the next cycle; state -> READ_WAIT or WRITE_WAIT.
REQ-028 WAIT: mem_*_valid SHALL hold until mem_*_ready sampled high; then mem_*_valid=0 next cycle, read data captured, state -> RELAY.
REQ-029 RELAY: consumer_*_ready of owner SHALL be 1 (read data driven) until owner's corresponding valid samples low; then ready=0, owner released, state -> IDLE.
REQ-030 consumer_read_data for a consumer SHALL hold the last captured value until that consumer's next read completes.
REQ-031 rr_ptr SHALL advance to (highest-searched granted consumer index + 1) mod NUM_CONSUMERS in any cycle with at least one grant; unchanged otherwise.
REQ-032 Minimum latency: valid rise at cycle t, mem_ready same cycle as mem_valid -> consumer ready at t+3.
REQ-033 A consumer SHALL never be owned by more than one channel; no consumer ready SHALL assert without a prior grant.
REQ-034 More pending consumers than channels: excess SHALL wait; with all requesters continuously pending, each is served within ceil(NUM_CONSUMERS/NUM_CHANNELS) grant rounds.
REQ-035 Consumer dropping valid during WAIT (protocol violation): memory transaction SHALL complete; RELAY SHALL exit after one cycle.

Reset
REQ-036 reset_n low SHALL immediately force all FSMs to IDLE, rr_ptr=0, all ownership cleared, all valid/ready outputs 0, all data/address outputs 0.
REQ-037 Reset mid-transaction SHALL abandon it; no completion reported after reset_n rises.

Verification (NUM_CONSUMERS=4, NUM_CHANNELS=2, ADDR_WIDTH=8, DATA_WIDTH=16)
REQ-038 Consumer 1 read addr 0x12, memory ready same cycle with 0xBEEF -> consumer_read_ready[1] at t+3, data 0xBEEF, held until valid drops.
REQ-039 All 4 consumers read at once -> channels 0/1 take consumers 0/1, then 2/3; no consumer served twice; rr_ptr 0->2->0.
REQ-040 Consumer 2 asserts read (0x05) and write (0x06, 0x1234) -> read completes first, then write on mem_write_addr=0x06, data 0x1234.
REQ-041 Memory ready delayed 5 cycles -> mem_read_valid held 5 cycles, address stable, consumer ready at t+8.
REQ-042 reset_n low during READ_WAIT -> mem_read_valid=0 immediately, no consumer ready after release, next request served normally.
REQ-043 Consumer 3 pending continuously while 0-2 re-request -> consumer 3 granted within 2 rounds.
